// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer in front of a single-transaction SRAM controller.
// Port 0 is the pipeline memory stage (stalled through freeze); port 1 is a secondary master.
module sram_arbiter #(
   parameter int TIMEOUT = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_wr_en,
   input  logic        p0_rd_en,
   input  logic [31:0] p0_address,
   input  logic [31:0] p0_write_data,
   output logic [31:0] p0_read_data,
   output logic        p0_ready,
   input  logic        p1_wr_en,
   input  logic        p1_rd_en,
   input  logic [31:0] p1_address,
   input  logic [31:0] p1_write_data,
   output logic [31:0] p1_read_data,
   output logic        p1_ready,
   output logic        freeze,
   output logic        mem_wr_en,
   output logic        mem_rd_en,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   input  logic        mem_ready,
   output logic        timeout_err
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam int         CW    = $clog2(TIMEOUT + 1);

   logic [1:0]    state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          gnt_q, gnt_d;
   logic          op_rd_q, op_rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_wr_en_q, mem_wr_en_d;
   logic          mem_rd_en_q, mem_rd_en_d;
   logic [31:0]   mem_address_q, mem_address_d;
   logic [31:0]   mem_write_data_q, mem_write_data_d;
   logic [31:0]   p0_read_data_q, p0_read_data_d;
   logic [31:0]   p1_read_data_q, p1_read_data_d;
   logic          p0_ready_q, p0_ready_d;
   logic          p1_ready_q, p1_ready_d;
   logic          timeout_err_q, timeout_err_d;
   logic          req0, req1, pick, finish, timed_out;
   logic [31:0]   rd_value;

   assign req0 = p0_wr_en | p0_rd_en;
   assign req1 = p1_wr_en | p1_rd_en;

   always_comb begin
      // NOTE: every target is given a default first, so no path leaves it unassigned and infers a latch.
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      gnt_d            = gnt_q;
      op_rd_d          = op_rd_q;
      cnt_d            = cnt_q;
      mem_wr_en_d      = 1'b0;
      mem_rd_en_d      = 1'b0;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      p0_read_data_d   = p0_read_data_q;
      p1_read_data_d   = p1_read_data_q;
      p0_ready_d       = 1'b0;
      p1_ready_d       = 1'b0;
      timeout_err_d    = timeout_err_q;
      finish           = 1'b0;
      timed_out        = 1'b0;
      rd_value         = mem_read_data;
      // Port 1 wins when alone, or on a tie when port 0 had the last grant.
      pick             = req1 & (~req0 | ~last_grant_q);

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               gnt_d            = pick;
               op_rd_d          = pick ? p1_rd_en : p0_rd_en;
               mem_address_d    = pick ? p1_address : p0_address;
               mem_write_data_d = pick ? p1_write_data : p0_write_data;
               mem_rd_en_d      = op_rd_d;
               mem_wr_en_d      = ~op_rd_d;
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_ready) begin
               finish = 1'b1;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               finish    = 1'b1;
               timed_out = 1'b1;
               rd_value  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            last_grant_d = gnt_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         state_d       = DONE;
         timeout_err_d = timeout_err_q | timed_out;
         p0_ready_d    = ~gnt_q;
         p1_ready_d    = gnt_q;
         if (op_rd_q & ~gnt_q) p0_read_data_d = rd_value;
         if (op_rd_q &  gnt_q) p1_read_data_d = rd_value;
      end
   end

   // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         last_grant_q     <= 1'b1;
         gnt_q            <= 1'b0;
         op_rd_q          <= 1'b0;
         cnt_q            <= '0;
         mem_wr_en_q      <= 1'b0;
         mem_rd_en_q      <= 1'b0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         p0_read_data_q   <= '0;
         p1_read_data_q   <= '0;
         p0_ready_q       <= 1'b0;
         p1_ready_q       <= 1'b0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         gnt_q            <= gnt_d;
         op_rd_q          <= op_rd_d;
         cnt_q            <= cnt_d;
         mem_wr_en_q      <= mem_wr_en_d;
         mem_rd_en_q      <= mem_rd_en_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         p0_read_data_q   <= p0_read_data_d;
         p1_read_data_q   <= p1_read_data_d;
         p0_ready_q       <= p0_ready_d;
         p1_ready_q       <= p1_ready_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   assign mem_wr_en      = mem_wr_en_q;
   assign mem_rd_en      = mem_rd_en_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign p0_read_data   = p0_read_data_q;
   assign p1_read_data   = p1_read_data_q;
   assign p0_ready       = p0_ready_q;
   assign p1_ready       = p1_ready_q;
   assign timeout_err    = timeout_err_q;
   assign freeze         = req0 & ~p0_ready_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized transactions against a
// transaction-level model that predicts grant order, strobe/ready cycles and read data.
module tb_sram_arbiter;
   localparam int TIMEOUT = 63;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_wr_en, p0_rd_en, p1_wr_en, p1_rd_en;
   logic [31:0] p0_address, p0_write_data, p1_address, p1_write_data;
   logic [31:0] p0_read_data, p1_read_data;
   logic        p0_ready, p1_ready, freeze;
   logic        mem_wr_en, mem_rd_en, mem_ready, timeout_err;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   int          vectors = 0;
   int          miscompares = 0;
   int          last_grant;
   logic [31:0] exp_rd [2];
   bit          exp_terr;
   int          resp_lat = -1;
   logic [31:0] resp_key = '0;
   bit          spur = 1'b0;

   sram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .p0_wr_en(p0_wr_en), .p0_rd_en(p0_rd_en), .p0_address(p0_address),
      .p0_write_data(p0_write_data), .p0_read_data(p0_read_data), .p0_ready(p0_ready),
      .p1_wr_en(p1_wr_en), .p1_rd_en(p1_rd_en), .p1_address(p1_address),
      .p1_write_data(p1_write_data), .p1_read_data(p1_read_data), .p1_ready(p1_ready),
      .freeze(freeze), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .mem_ready(mem_ready), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
      check1({tag, "_mem_wr_en"}, mem_wr_en, 1'b0);
      check32({tag, "_mem_address"}, mem_address, 32'h0);
      check32({tag, "_mem_write_data"}, mem_write_data, 32'h0);
      check32({tag, "_p0_read_data"}, p0_read_data, 32'h0);
      check32({tag, "_p1_read_data"}, p1_read_data, 32'h0);
      check1({tag, "_p0_ready"}, p0_ready, 1'b0);
      check1({tag, "_p1_ready"}, p1_ready, 1'b0);
      check1({tag, "_timeout_err"}, timeout_err, 1'b0);
   endtask

   // Controller model: answers each strobe after resp_lat cycles (never if negative) with address ^ key.
   initial begin
      mem_ready     = 1'b0;
      mem_read_data = '0;
      forever begin
         @(negedge clk);
         mem_ready     = spur;
         mem_read_data = $urandom;
         if (rst && (mem_rd_en || mem_wr_en) && resp_lat >= 0) begin
            repeat (resp_lat) begin
               @(negedge clk);
               mem_read_data = $urandom;
            end
            mem_read_data = mem_address ^ resp_key;
            mem_ready     = 1'b1;
            @(negedge clk);
            mem_ready     = 1'b0;
            mem_read_data = $urandom;
         end
      end
   end

   // One request round: the enabled ports raise requests together and each drops on seeing its ready.
   // Cycle k counts negedges after the requests were driven; the first strobe is expected at k = 1.
   task automatic txn(input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] d1,
                      input int lat, input logic [31:0] key);
      logic [1:0]  ops [2];
      logic [31:0] adr [2];
      logic [31:0] dat [2];
      int          port [2];
      int          s [2];
      int          r [2];
      int          n, dur, r_p0, k_end;
      bit          timed, stb_rd, stb_wr;
      bit          rdy [2];
      ops[0] = op0; adr[0] = a0; dat[0] = d0;
      ops[1] = op1; adr[1] = a1; dat[1] = d1;
      timed  = !(lat >= 0 && lat <= TIMEOUT);
      dur    = timed ? TIMEOUT + 1 : lat + 1;
      n      = 0;
      port   = '{0, 0};
      if (op0 != 0 && op1 != 0) begin
         port[0] = 1 - last_grant;
         port[1] = last_grant;
         n       = 2;
      end else if (op0 != 0) begin
         n = 1;
      end else if (op1 != 0) begin
         port[0] = 1;
         n       = 1;
      end
      r_p0 = 0;
      for (int i = 0; i < n; i++) begin
         s[i] = (i == 0) ? 1 : r[i-1] + 2;
         r[i] = s[i] + dur;
         if (port[i] == 0) r_p0 = r[i];
      end
      k_end = (n > 0) ? r[n-1] + 2 : 2;

      @(negedge clk);
      resp_lat = lat;
      resp_key = key;
      p0_rd_en = op0[1]; p0_wr_en = op0[0]; p0_address = a0; p0_write_data = d0;
      p1_rd_en = op1[1]; p1_wr_en = op1[0]; p1_address = a1; p1_write_data = d1;

      for (int k = 1; k <= k_end; k++) begin
         @(negedge clk);
         stb_rd = 1'b0; stb_wr = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (k == s[i]) begin
               if (ops[port[i]][1]) stb_rd = 1'b1;
               else                 stb_wr = 1'b1;
            end
            if (k >= s[i] && k <= r[i]) begin
               check32("mem_address", mem_address, adr[port[i]]);
               check32("mem_write_data", mem_write_data, dat[port[i]]);
            end
            if (k == r[i]) begin
               rdy[port[i]] = 1'b1;
               last_grant   = port[i];
               if (timed) exp_terr = 1'b1;
               if (ops[port[i]][1]) exp_rd[port[i]] = timed ? 32'h0 : adr[port[i]] ^ key;
            end
         end
         check1("mem_rd_en", mem_rd_en, stb_rd);
         check1("mem_wr_en", mem_wr_en, stb_wr);
         check1("p0_ready", p0_ready, rdy[0]);
         check1("p1_ready", p1_ready, rdy[1]);
         check1("freeze", freeze, (op0 != 0) && (k < r_p0));
         check32("p0_read_data", p0_read_data, exp_rd[0]);
         check32("p1_read_data", p1_read_data, exp_rd[1]);
         check1("timeout_err", timeout_err, exp_terr);
         if (p0_ready) begin p0_rd_en = 1'b0; p0_wr_en = 1'b0; end
         if (p1_ready) begin p1_rd_en = 1'b0; p1_wr_en = 1'b0; end
      end
      p0_rd_en = 1'b0; p0_wr_en = 1'b0; p1_rd_en = 1'b0; p1_wr_en = 1'b0;
   endtask

   initial begin
      logic [1:0] o0, o1;
      rst = 1'b1;
      p0_wr_en = 1'b0; p0_rd_en = 1'b0; p0_address = '0; p0_write_data = '0;
      p1_wr_en = 1'b0; p1_rd_en = 1'b0; p1_address = '0; p1_write_data = '0;
      last_grant = 1; exp_rd[0] = '0; exp_rd[1] = '0; exp_terr = 1'b0;

      #1 rst = 1'b0;
      #1;
      check_all_zero("reset");
      check1("reset_freeze", freeze, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Simultaneous requests from both ports, three rounds; the first tie goes to port 0.
      repeat (3) begin
         o0 = 2'($urandom_range(1, 3));
         o1 = 2'($urandom_range(1, 3));
         txn(o0, $urandom, $urandom, o1, $urandom, $urandom, $urandom_range(1, 5), $urandom);
      end

      // Port 0 read of 0x104 answered with 0xCAFE_F00D four cycles after the strobe.
      txn(2'b10, 32'h0000_0104, $urandom, 2'b00, '0, '0, 4, 32'h0000_0104 ^ 32'hCAFE_F00D);
      check32("p0_cafef00d", p0_read_data, 32'hCAFE_F00D);

      // Port 1 write while port 0 is idle.
      txn(2'b00, '0, '0, 2'b01, 32'h0000_0200, 32'h1234_5678, 3, $urandom);

      // Controller ready while idle must be ignored.
      @(negedge clk);
      spur = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check1("spur_p0_ready", p0_ready, 1'b0);
         check1("spur_p1_ready", p1_ready, 1'b0);
         check1("spur_mem_rd_en", mem_rd_en, 1'b0);
      end
      spur = 1'b0;
      repeat (2) @(negedge clk);
      check32("spur_p0_read_data", p0_read_data, exp_rd[0]);
      check32("spur_p1_read_data", p1_read_data, exp_rd[1]);

      // Both read and write enables: a read.
      txn(2'b11, $urandom, $urandom, 2'b00, '0, '0, 2, $urandom);

      // Silent controller, then a normal transaction with the sticky error still set.
      txn(2'b10, $urandom, $urandom, 2'b00, '0, '0, -1, $urandom);
      txn(2'b00, '0, '0, 2'b10, $urandom, $urandom, 2, $urandom);

      // Latency boundaries: ready in the last WAIT cycle, and one cycle too late.
      txn(2'b10, $urandom, $urandom, 2'b00, '0, '0, TIMEOUT, $urandom);
      txn(2'b10, $urandom, $urandom, 2'b00, '0, '0, TIMEOUT + 1, $urandom);

      // Reset in the middle of WAIT.
      @(negedge clk);
      resp_lat = -1;
      p0_rd_en = 1'b1; p0_address = 32'h0000_0ABC;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("rst_wait");
      last_grant = 1; exp_rd[0] = '0; exp_rd[1] = '0; exp_terr = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check1("rst_hold_p0_ready", p0_ready, 1'b0);
      end
      p0_rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      txn(2'b10, $urandom, $urandom, 2'b00, '0, '0, $urandom_range(1, 6), $urandom);

      // Randomized rounds.
      repeat (20) begin
         o0 = 2'($urandom_range(0, 3));
         o1 = 2'($urandom_range(0, 3));
         if (o0 == 2'b00 && o1 == 2'b00) o0 = 2'b10;
         txn(o0, $urandom, $urandom, o1, $urandom, $urandom, $urandom_range(1, 6), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
